// File: rtl/alarm_pkg.sv
// Shared types and constants for the multi-channel alarm controller.
// Provides the per-channel state encoding, the BCD field width, the LED
// patterns, and helpers that size the ring and snooze counters.
package alarm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZE  = 2'd2
    } alarm_state_e;

    localparam int BCD_W = 8;

    localparam logic [3:0] LED_ON  = 4'b1111;
    localparam logic [3:0] LED_SNZ = 4'b0001;
    localparam logic [3:0] LED_OFF = 4'b0000;

    function automatic int ring_cnt_w(input int ring_sec);
        return $clog2(ring_sec + 1);
    endfunction

    function automatic int snz_tmr_w(input int snooze_sec);
        return $clog2(snooze_sec + 1);
    endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: edge-triggered time match, IDLE/RINGING/SNOOZE FSM,
// ring-duration counter, snooze timer and snooze count.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   sec_tick_i               one-cycle pulse per second
//   hr_i, mn_i               current BCD time
//   hr_alarm_i, mn_alarm_i   programmed BCD alarm time
//   en_i                     channel enable
//   btn_snooze_i/dismiss_i   one-cycle button pulses
//   ringing_o, snoozing_o    registered state flags
//   ring_nx_o, snz_nx_o      next-state flags (for the shared LED register)
module alarm_channel
    import alarm_pkg::*;
#(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300,
    parameter int MAX_SNOOZE = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sec_tick_i,
    input  logic [BCD_W-1:0] hr_i,
    input  logic [BCD_W-1:0] mn_i,
    input  logic [BCD_W-1:0] hr_alarm_i,
    input  logic [BCD_W-1:0] mn_alarm_i,
    input  logic             en_i,
    input  logic             btn_snooze_i,
    input  logic             btn_dismiss_i,
    output logic             ringing_o,
    output logic             snoozing_o,
    output logic             ring_nx_o,
    output logic             snz_nx_o
);

    localparam int RW = ring_cnt_w(RING_SEC);
    localparam int SW = snz_tmr_w(SNOOZE_SEC);
    localparam logic [RW-1:0] RING_LOAD = RW'(RING_SEC);
    localparam logic [SW-1:0] SNZ_LOAD  = SW'(SNOOZE_SEC);
    localparam logic [2:0]    MAX_S     = 3'(MAX_SNOOZE);

    alarm_state_e  state_q, state_d;
    logic [RW-1:0] ring_q, ring_d;
    logic [SW-1:0] tmr_q, tmr_d;
    logic [2:0]    snz_q, snz_d;
    logic          match_d_q;
    logic          match, trig;

    assign match = en_i && (hr_i == hr_alarm_i) && (mn_i == mn_alarm_i);
    // match_d_q resets high so a match already present at reset release is
    // not treated as a new edge.
    assign trig  = match & ~match_d_q;

    always_comb begin
        state_d = state_q;
        ring_d  = ring_q;
        tmr_d   = tmr_q;
        snz_d   = snz_q;
        if (!en_i) begin
            state_d = ST_IDLE;
        end else if (btn_dismiss_i && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
        end else if (trig) begin
            state_d = ST_RINGING;
            ring_d  = RING_LOAD;
            snz_d   = '0;
        end else begin
            case (state_q)
                ST_RINGING: begin
                    if (btn_snooze_i) begin
                        if (snz_q < MAX_S) begin
                            state_d = ST_SNOOZE;
                            tmr_d   = SNZ_LOAD;
                            snz_d   = snz_q + 3'd1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else if (sec_tick_i) begin
                        // Expire on the tick that would take the count to 0.
                        if (ring_q <= RW'(1)) begin
                            state_d = ST_IDLE;
                            ring_d  = '0;
                        end else begin
                            ring_d = ring_q - RW'(1);
                        end
                    end
                end
                ST_SNOOZE: begin
                    if (sec_tick_i) begin
                        if (tmr_q <= SW'(1)) begin
                            state_d = ST_RINGING;
                            ring_d  = RING_LOAD;
                            tmr_d   = '0;
                        end else begin
                            tmr_d = tmr_q - SW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ring_q    <= '0;
            tmr_q     <= '0;
            snz_q     <= '0;
            match_d_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            ring_q    <= ring_d;
            tmr_q     <= tmr_d;
            snz_q     <= snz_d;
            match_d_q <= match;
        end
    end

    assign ringing_o  = (state_q == ST_RINGING);
    assign snoozing_o = (state_q == ST_SNOOZE);
    assign ring_nx_o  = (state_d == ST_RINGING);
    assign snz_nx_o   = (state_d == ST_SNOOZE);

endmodule

// File: rtl/alarm_ctrl.sv
// Multi-channel alarm controller: N_ALARM independent alarm channels plus a
// shared blinking LED driver.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   sec_tick              one-cycle pulse per second
//   hr, mn                current BCD time
//   hr_alarm, mn_alarm    packed BCD alarm times, channel i at [8i+7:8i]
//   alarm_en              per-channel enable
//   btn_snooze/dismiss    one-cycle button pulses, applied to all channels
//   ringing, snoozing     per-channel state flags
//   led_alarm             blink while any ringing, 0001 while snoozing only
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int N_ALARM    = 2,
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300,
    parameter int MAX_SNOOZE = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sec_tick,
    input  logic [BCD_W-1:0]         hr,
    input  logic [BCD_W-1:0]         mn,
    input  logic [BCD_W*N_ALARM-1:0] hr_alarm,
    input  logic [BCD_W*N_ALARM-1:0] mn_alarm,
    input  logic [N_ALARM-1:0]       alarm_en,
    input  logic                     btn_snooze,
    input  logic                     btn_dismiss,
    output logic [N_ALARM-1:0]       ringing,
    output logic [N_ALARM-1:0]       snoozing,
    output logic [3:0]               led_alarm
);

    logic [N_ALARM-1:0] ring_w, snz_w, ring_nx, snz_nx;
    logic               blink_q, blink_d;
    logic [3:0]         led_q, led_d;

    for (genvar g = 0; g < N_ALARM; g++) begin : g_ch
        alarm_channel #(
            .RING_SEC  (RING_SEC),
            .SNOOZE_SEC(SNOOZE_SEC),
            .MAX_SNOOZE(MAX_SNOOZE)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .sec_tick_i   (sec_tick),
            .hr_i         (hr),
            .mn_i         (mn),
            .hr_alarm_i   (hr_alarm[BCD_W*g +: BCD_W]),
            .mn_alarm_i   (mn_alarm[BCD_W*g +: BCD_W]),
            .en_i         (alarm_en[g]),
            .btn_snooze_i (btn_snooze),
            .btn_dismiss_i(btn_dismiss),
            .ringing_o    (ring_w[g]),
            .snoozing_o   (snz_w[g]),
            .ring_nx_o    (ring_nx[g]),
            .snz_nx_o     (snz_nx[g])
        );
    end

    // LED is computed from the channels' next state so it changes on the
    // same edge as ringing/snoozing.
    always_comb begin
        blink_d = blink_q;
        led_d   = LED_OFF;
        if (|ring_nx && !(|ring_w)) begin
            blink_d = 1'b1;
        end else if (sec_tick) begin
            blink_d = ~blink_q;
        end
        if (|ring_nx) begin
            led_d = blink_d ? LED_ON : LED_OFF;
        end else if (|snz_nx) begin
            led_d = LED_SNZ;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_q <= 1'b0;
            led_q   <= LED_OFF;
        end else begin
            blink_q <= blink_d;
            led_q   <= led_d;
        end
    end

    assign ringing   = ring_w;
    assign snoozing  = snz_w;
    assign led_alarm = led_q;

endmodule
